issue_sched: RTL and testbench
==============================

ISSUE_SCHED -- requirements
Module: issue_sched

Interface
REQ-001 Parameter: DEPTH, 4, entries per requester FIFO (power of two, >=2).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 __START__  input  1  pipeline advance enable; issue and FSM progress only on edges where high.
REQ-005 req0_valid / req1_valid  input  1  requester k offers an instruction.
REQ-006 req0_inst / req1_inst  input  8  instruction {op[7:6], rs1[5:4], rs2[3:2], rd[1:0]}.
REQ-007 req0_ready / req1_ready  output  1  requester k FIFO accepts this cycle.
REQ-008 drain  input  1  level request to stop intake and empty the pipeline.
REQ-009 inst  output  8  registered instruction presented to the pipeline.
REQ-010 inst_valid  output  1  inst holds a requester instruction (0 = scheduler-inserted NOP).
REQ-011 inst_src  output  1  requester index of inst; 0 when inst_valid=0.
REQ-012 issue_cnt0 / issue_cnt1  output  8  count of instructions issued per requester.
REQ-013 drain_done  output  1  high while in DONE state.

Function
REQ-014 Each requester SHALL have an independent DEPTH-entry FIFO; push on any edge with reqK_valid && reqK_ready, regardless of __START__.
REQ-015 reqK_ready SHALL be combinational: high iff FSM in RUN and FIFO K not full.
REQ-016 On an edge with __START__=1, scheduler SHALL load inst from the head of the selected FIFO and pop it; no selection when both empty -> inst=8'h00, inst_valid=0, inst_src=0.
REQ-017 On an edge with __START__=0, inst, inst_valid, inst_src, pointer, counters and FSM SHALL hold.
REQ-018 Selection SHALL be round-robin: pointer p names favored requester; if FIFO p non-empty pick p, else pick other if non-empty.
REQ-019 After issuing from requester k, p SHALL become ~k; p holds when nothing issues.
REQ-020 Instructions SHALL be issued unmodified, including op=00 entries (counted as issued, inst_valid=1).
REQ-021 Push to an empty FIFO at edge N SHALL make the entry issuable no earlier than edge N+1 (no bypass).
REQ-022 Simultaneous push and pop on the same FIFO SHALL both take effect; occupancy unchanged; push while full is impossible (ready=0).
REQ-023 issue_cntK SHALL increment by 1 on each issue from K and wrap 255 -> 0.
REQ-024 FSM states RUN, DRAIN, FLUSH, DONE; reset state RUN.
REQ-025 RUN -> DRAIN on any edge with drain=1 (independent of __START__); push accepted in that same cycle is kept.
REQ-026 DRAIN: both ready low; issue continues; -> FLUSH on a __START__ edge when both FIFOs are empty at that edge (flush counter cleared).
REQ-027 FLUSH: issues NOPs; counter increments on each __START__ edge; -> DONE on the __START__ edge where counter==2 (last instruction has reached register writeback).
REQ-028 DONE: drain_done=1, ready low; -> RUN on edge with drain=0.
REQ-029 drain deasserted during DRAIN or FLUSH SHALL NOT abort; sequence completes to DONE.

Reset
REQ-030 On rst edge: FIFOs emptied, p=0, inst=8'h00, inst_valid=0, inst_src=0, issue_cnt0=issue_cnt1=0, FSM=RUN, flush counter=0.
REQ-031 rst SHALL take priority over all other inputs, including mid-drain and __START__=0; no pending entry survives.
REQ-032 Outputs SHALL carry no X after the first reset edge.

Verification
REQ-033 Both requesters push continuously (r0: 8'h41,8'h42..., r1: 8'h81,8'h82...), __START__=1 -> inst alternates 41,81,42,82...; inst_src 0,1,0,1; counters equal.
REQ-034 Only r1 pushes 5 entries while __START__=0 -> 4 accepted, req1_ready low after 4th; raising __START__ issues them in order, p ends at 0, issue_cnt1=4.
REQ-035 Both FIFOs empty, __START__=1 -> inst=8'h00, inst_valid=0 every cycle; counters unchanged.
REQ-036 Push 3 to r0, assert drain -> readies drop next cycle; 3 issues, then drain_done rises exactly 3 __START__ edges after the edge that issued the last entry; drop drain -> RUN, readies return.
REQ-037 Issue 256 instructions from r0 -> issue_cnt0 returns to 0.
REQ-038 rst asserted during FLUSH with __START__=0 -> next cycle all outputs at reset values, FSM RUN, readies high.

Source files
------------

// File: rtl/issue_sched.sv
// Two-requester round-robin issue scheduler with per-requester FIFOs and a
// drain sequence (RUN -> DRAIN -> FLUSH -> DONE) that empties the pipeline.
module issue_sched #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       __START__,
  input  logic       req0_valid,
  input  logic [7:0] req0_inst,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_inst,
  output logic       req1_ready,
  input  logic       drain,
  output logic [7:0] inst,
  output logic       inst_valid,
  output logic       inst_src,
  output logic [7:0] issue_cnt0,
  output logic [7:0] issue_cnt1,
  output logic       drain_done
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_RUN,
    S_DRAIN,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  flush_q, flush_d;
  logic        ptr_q, ptr_d;
  logic [7:0]  inst_q, inst_d;
  logic        vld_q, vld_d;
  logic        src_q, src_d;
  logic [7:0]  cnt_q [2];
  logic [7:0]  cnt_d [2];
  logic [AW:0] wr_q  [2];
  logic [AW:0] wr_d  [2];
  logic [AW:0] rd_q  [2];
  logic [AW:0] rd_d  [2];
  logic [7:0]  mem_q [2][DEPTH];

  logic [7:0]  req_inst [2];
  logic [1:0]  req_valid;
  logic [1:0]  ready;
  logic [1:0]  empty;
  logic [1:0]  full;
  logic [1:0]  push;
  logic [1:0]  pop;
  logic        issue_en;
  logic        sel;

  assign req_inst[0] = req0_inst;
  assign req_inst[1] = req1_inst;
  assign req_valid   = {req1_valid, req0_valid};

  // FIFO status and requester handshake
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      empty[k] = (wr_q[k] == rd_q[k]);
      full[k]  = (wr_q[k][AW] != rd_q[k][AW]) &&
                 (wr_q[k][AW-1:0] == rd_q[k][AW-1:0]);
      ready[k] = (state_q == S_RUN) && !full[k];
      push[k]  = req_valid[k] && ready[k];
    end
  end

  assign req0_ready = ready[0];
  assign req1_ready = ready[1];

  // Round-robin pick: favored requester first, otherwise the other one
  always_comb begin
    issue_en = 1'b0;
    sel      = 1'b0;
    if (__START__) begin
      if (!empty[ptr_q]) begin
        issue_en = 1'b1;
        sel      = ptr_q;
      end else if (!empty[~ptr_q]) begin
        issue_en = 1'b1;
        sel      = ~ptr_q;
      end
    end
    pop = 2'b00;
    if (issue_en) pop[sel] = 1'b1;
  end

  always_comb begin
    inst_d = inst_q;
    vld_d  = vld_q;
    src_d  = src_q;
    ptr_d  = ptr_q;
    for (int k = 0; k < 2; k++) begin
      cnt_d[k] = cnt_q[k] + (pop[k] ? 8'd1 : 8'd0);
      wr_d[k]  = wr_q[k] + (push[k] ? (AW+1)'(1) : (AW+1)'(0));
      rd_d[k]  = rd_q[k] + (pop[k] ? (AW+1)'(1) : (AW+1)'(0));
    end
    if (__START__) begin
      inst_d = issue_en ? mem_q[sel][rd_q[sel][AW-1:0]] : 8'h00;
      vld_d  = issue_en;
      src_d  = issue_en && sel;
      if (issue_en) ptr_d = ~sel;
    end
  end

  // Drain FSM; the flush count covers the pipeline depth behind the issue register
  always_comb begin
    state_d = state_q;
    flush_d = flush_q;
    case (state_q)
      S_RUN: begin
        if (drain) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (__START__ && (&empty)) begin
          state_d = S_FLUSH;
          flush_d = 2'd0;
        end
      end
      S_FLUSH: begin
        if (__START__) begin
          flush_d = flush_q + 2'd1;
          if (flush_q == 2'd1) state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (__START__ && !drain) state_d = S_RUN;
      end
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RUN;
      flush_q <= 2'd0;
      ptr_q   <= 1'b0;
      inst_q  <= 8'h00;
      vld_q   <= 1'b0;
      src_q   <= 1'b0;
      for (int k = 0; k < 2; k++) begin
        cnt_q[k] <= 8'd0;
        wr_q[k]  <= '0;
        rd_q[k]  <= '0;
      end
    end else begin
      state_q <= state_d;
      flush_q <= flush_d;
      ptr_q   <= ptr_d;
      inst_q  <= inst_d;
      vld_q   <= vld_d;
      src_q   <= src_d;
      for (int k = 0; k < 2; k++) begin
        cnt_q[k] <= cnt_d[k];
        wr_q[k]  <= wr_d[k];
        rd_q[k]  <= rd_d[k];
      end
    end
  end

  // FIFO storage is never read while empty, so it needs no reset
  always_ff @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (push[k]) mem_q[k][wr_q[k][AW-1:0]] <= req_inst[k];
    end
  end

  assign inst       = inst_q;
  assign inst_valid = vld_q;
  assign inst_src   = src_q;
  assign issue_cnt0 = cnt_q[0];
  assign issue_cnt1 = cnt_q[1];
  assign drain_done = (state_q == S_DONE);

endmodule

// File: tb/tb_issue_sched.sv
// Directed self-checking bench for issue_sched: round-robin issue, FIFO full,
// idle NOPs, drain sequence timing, counter wrap and reset during flush.
module tb_issue_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       req0_valid, req1_valid;
  logic [7:0] req0_inst, req1_inst;
  logic       req0_ready, req1_ready;
  logic       drain;
  logic [7:0] inst;
  logic       inst_valid, inst_src;
  logic [7:0] issue_cnt0, issue_cnt1;
  logic       drain_done;

  int n_checks = 0;
  int n_fail   = 0;

  issue_sched #(.DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .__START__  (start),
    .req0_valid (req0_valid),
    .req0_inst  (req0_inst),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_inst  (req1_inst),
    .req1_ready (req1_ready),
    .drain      (drain),
    .inst       (inst),
    .inst_valid (inst_valid),
    .inst_src   (inst_src),
    .issue_cnt0 (issue_cnt0),
    .issue_cnt1 (issue_cnt1),
    .drain_done (drain_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [7:0] e_inst, input logic e_vld, input logic e_src);
    chk({tag, ".inst"}, 32'(inst), 32'(e_inst));
    chk({tag, ".vld"},  32'(inst_valid), 32'(e_vld));
    chk({tag, ".src"},  32'(inst_src), 32'(e_src));
  endtask

  initial begin
    logic [7:0] a0, a1;
    logic       r0v, r1v, rd0, rd1;
    int         acc1;

    rst = 1'b1; start = 1'b0; drain = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; req0_inst = 8'h00; req1_inst = 8'h00;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    chk_out("rst", 8'h00, 1'b0, 1'b0);
    chk("rst.cnt0", 32'(issue_cnt0), 0);
    chk("rst.cnt1", 32'(issue_cnt1), 0);
    chk("rst.dd",   32'(drain_done), 0);
    chk("rst.rdy0", 32'(req0_ready), 1);
    chk("rst.rdy1", 32'(req1_ready), 1);

    // Idle with both FIFOs empty: NOPs, counters untouched
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out("idle", 8'h00, 1'b0, 1'b0);
    end
    chk("idle.cnt0", 32'(issue_cnt0), 0);

    // Both requesters push continuously; issue alternates r0/r1
    a0 = 8'h00; a1 = 8'h00;
    for (int e = 1; e <= 17; e++) begin
      r0v = (e <= 9); r1v = (e <= 9);
      req0_valid = r0v; req0_inst = 8'h41 + a0;
      req1_valid = r1v; req1_inst = 8'h81 + a1;
      rd0 = req0_ready; rd1 = req1_ready;
      tick();
      if (r0v && rd0) a0++;
      if (r1v && rd1) a1++;
      if (e >= 2 && e <= 16) begin
        if ((e - 2) % 2 == 0) chk_out("rr", 8'h41 + 8'((e - 2) / 2), 1'b1, 1'b0);
        else                  chk_out("rr", 8'h81 + 8'((e - 2) / 2), 1'b1, 1'b1);
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk_out("rr.end", 8'h00, 1'b0, 1'b0);
    chk("rr.acc0", 32'(a0), 8);
    chk("rr.acc1", 32'(a1), 7);
    chk("rr.cnt0", 32'(issue_cnt0), 8);
    chk("rr.cnt1", 32'(issue_cnt1), 7);

    // r1 alone offers 5 entries with issue stalled: only 4 fit
    start = 1'b0;
    acc1 = 0;
    for (int i = 0; i < 5; i++) begin
      req1_valid = 1'b1; req1_inst = 8'hC1 + 8'(acc1);
      rd1 = req1_ready;
      tick();
      if (rd1) acc1++;
    end
    chk("full.acc", 32'(acc1), 4);
    chk("full.rdy1", 32'(req1_ready), 0);
    chk_out("full.hold", 8'h00, 1'b0, 1'b0);
    req1_valid = 1'b0;
    start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_out("full.iss", 8'hC1 + 8'(i), 1'b1, 1'b1);
    end
    chk("full.cnt1", 32'(issue_cnt1), 11);
    // Pointer must now favor r0
    start = 1'b0;
    req0_valid = 1'b1; req0_inst = 8'hD0;
    req1_valid = 1'b1; req1_inst = 8'hD1;
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    start = 1'b1;
    tick();
    chk_out("ptr.r0", 8'hD0, 1'b1, 1'b0);
    tick();
    chk_out("ptr.r1", 8'hD1, 1'b1, 1'b1);
    tick();
    chk_out("ptr.nop", 8'h00, 1'b0, 1'b0);
    chk("ptr.cnt0", 32'(issue_cnt0), 9);
    chk("ptr.cnt1", 32'(issue_cnt1), 12);

    // Drain sequence
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req0_valid = 1'b1; req0_inst = 8'h11 + 8'(i);
      tick();
    end
    req0_valid = 1'b0;
    drain = 1'b1;
    tick();
    chk("drn.rdy0", 32'(req0_ready), 0);
    chk("drn.rdy1", 32'(req1_ready), 0);
    chk("drn.dd0",  32'(drain_done), 0);
    start = 1'b1;
    tick();
    chk_out("drn.i1", 8'h11, 1'b1, 1'b0);
    start = 1'b0;
    tick();
    chk_out("drn.hold", 8'h11, 1'b1, 1'b0);
    chk("drn.holdcnt", 32'(issue_cnt0), 10);
    start = 1'b1;
    tick();
    chk_out("drn.i2", 8'h12, 1'b1, 1'b0);
    tick();
    chk_out("drn.i3", 8'h13, 1'b1, 1'b0);
    tick();
    chk_out("drn.f1", 8'h00, 1'b0, 1'b0);
    chk("drn.dd1", 32'(drain_done), 0);
    drain = 1'b0;
    tick();
    chk("drn.dd2", 32'(drain_done), 0);
    tick();
    chk("drn.dd3", 32'(drain_done), 1);
    chk("drn.rdyD", 32'(req0_ready), 0);
    tick();
    chk("drn.ddR", 32'(drain_done), 0);
    chk("drn.rdyR", 32'(req0_ready), 1);
    chk("drn.cnt0", 32'(issue_cnt0), 12);

    // 256 issues from r0 wrap the counter; last entry is op=00
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int e = 1; e <= 257; e++) begin
      req0_valid = (e <= 256);
      req0_inst  = 8'(e);
      tick();
      if (e == 256) chk("wrap.255", 32'(issue_cnt0), 255);
    end
    req0_valid = 1'b0;
    chk("wrap.0", 32'(issue_cnt0), 0);
    chk_out("wrap.op00", 8'h00, 1'b1, 1'b0);

    // Reset in FLUSH with issue stalled
    start = 1'b0;
    req0_valid = 1'b1; req0_inst = 8'h55;
    tick();
    req0_valid = 1'b0;
    drain = 1'b1;
    tick();
    start = 1'b1;
    tick();
    chk_out("rf.iss", 8'h55, 1'b1, 1'b0);
    tick();
    chk("rf.dd", 32'(drain_done), 0);
    chk("rf.rdy", 32'(req0_ready), 0);
    start = 1'b0; rst = 1'b1;
    req1_valid = 1'b1; req1_inst = 8'hEE;
    tick();
    rst = 1'b0; drain = 1'b0; req1_valid = 1'b0;
    chk_out("rf.rst", 8'h00, 1'b0, 1'b0);
    chk("rf.cnt0", 32'(issue_cnt0), 0);
    chk("rf.cnt1", 32'(issue_cnt1), 0);
    chk("rf.dd0",  32'(drain_done), 0);
    chk("rf.rdy0", 32'(req0_ready), 1);
    chk("rf.rdy1", 32'(req1_ready), 1);
    start = 1'b1;
    tick();
    chk_out("rf.empty", 8'h00, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
